// File: rtl/s_wb_sched.sv
// s_wb_sched: scalar-unit writeback port reservation and S-register busy tracking.
// Define S_SCHED_WB_BYPASS_EN to treat a register being written back this cycle as free.
module s_wb_sched #(
  parameter int MAX_LAT = 14,
  parameter int NUM_S = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_issue,
  input  logic [2:0]       i_unit,
  input  logic [3:0]       i_lat,
  input  logic [2:0]       i_dest,
  input  logic             i_srcj_use,
  input  logic [2:0]       i_srcj,
  input  logic             i_srck_use,
  input  logic [2:0]       i_srck,
  output logic             o_grant,
  output logic             o_stall,
  output logic             o_err,
  output logic             o_wb_valid,
  output logic [2:0]       o_wb_dest,
  output logic [2:0]       o_wb_unit,
  output logic [NUM_S-1:0] o_s_busy,
  output logic [3:0]       o_pending
);
  localparam logic [3:0] ML = 4'(MAX_LAT);
  logic [MAX_LAT:1] cv, ld;
  logic [MAX_LAT:1][2:0] cd, cu;
  logic [NUM_S-1:0] wb_clr, busy_chk, set;
  logic lat_ok;
  always_comb begin
    lat_ok = i_lat != 4'd0 && i_lat <= ML;
    wb_clr = o_wb_valid ? NUM_S'(1) << o_wb_dest : '0;
`ifdef S_SCHED_WB_BYPASS_EN
    busy_chk = o_s_busy & ~wb_clr;
`else
    busy_chk = o_s_busy;
`endif
    o_err = !rst && i_issue && !lat_ok;
    o_grant = !rst && i_issue && lat_ok && !cv[i_lat] && !busy_chk[i_dest] &&
              !(i_srcj_use && busy_chk[i_srcj]) && !(i_srck_use && busy_chk[i_srck]);
    o_stall = i_issue && !o_grant && !o_err;
    set = o_grant ? NUM_S'(1) << i_dest : '0;
    ld = '0;
    for (int k = 1; k <= MAX_LAT; k++) ld[k] = o_grant && i_lat == 4'(k);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cv <= '0;
      cd <= '0;
      cu <= '0;
      o_wb_valid <= 1'b0;
      o_wb_dest <= '0;
      o_wb_unit <= '0;
      o_s_busy <= '0;
      o_pending <= '0;
    end else begin
      o_wb_valid <= cv[1] | ld[1];
      o_wb_dest <= ld[1] ? i_dest : cd[1];
      o_wb_unit <= ld[1] ? i_unit : cu[1];
      for (int k = 1; k < MAX_LAT; k++) begin
        cv[k] <= cv[k+1] | ld[k+1];
        cd[k] <= ld[k+1] ? i_dest : cd[k+1];
        cu[k] <= ld[k+1] ? i_unit : cu[k+1];
      end
      cv[MAX_LAT] <= 1'b0;
      cd[MAX_LAT] <= '0;
      cu[MAX_LAT] <= '0;
      o_s_busy <= (o_s_busy & ~wb_clr) | set;
      o_pending <= o_pending + {3'b0, o_grant} - {3'b0, o_wb_valid};
    end
  end
endmodule

// File: doc/s_wb_sched.md
Name: s_wb_sched

Overview:
- Issue-side scheduler for the scalar functional units: constant generator, scalar add, logical, shift, pop/parity, and the floating-point units.
- Every scalar unit has a fixed latency. This block reserves the single S-register writeback port, tracks S-register busy bits, and grants or stalls each scalar issue.
- Its output sequences the S-register file write strobe and the result mux select.

Parameters:
- MAX_LAT, 14, deepest scalar unit latency in clocks (reciprocal approximation); sets the reservation chain depth.
- NUM_S, 8, number of S registers; sets the busy vector width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- i_issue  input  1  issue request for a scalar-result instruction this cycle
- i_unit  input  3  functional-unit tag, echoed at writeback to drive the result mux
- i_lat  input  4  unit latency in clocks, legal range 1..MAX_LAT
- i_dest  input  3  destination S register index
- i_srcj_use  input  1  Sj operand is read
- i_srcj  input  3  Sj index
- i_srck_use  input  1  Sk operand is read
- i_srck  input  3  Sk index
- o_grant  output  1  combinational; issue accepted this cycle
- o_stall  output  1  combinational; i_issue & ~o_grant & ~o_err
- o_err  output  1  combinational; i_issue with i_lat==0 or i_lat>MAX_LAT
- o_wb_valid  output  1  registered S-register write strobe
- o_wb_dest  output  3  registered write index
- o_wb_unit  output  3  registered result mux select
- o_s_busy  output  NUM_S  registered; S registers with a pending write
- o_pending  output  4  registered count of in-flight reservations

Behaviour:
- Reservation chain:
  - Slots c[1..MAX_LAT], each holding {valid, dest, unit}.
  - If c[k] is valid in cycle T, that writeback occurs (o_wb_valid high) in cycle T+k.
- Every posedge, when not in reset:
  - o_wb_* <= c[1].
  - c[k] <= c[k+1]; c[MAX_LAT] <= invalid.
  - On grant with latency L: the new entry is placed at position L-1 after the shift. L==1 loads o_wb_* directly.
- Grant condition, all required:
  - i_issue is high, and i_lat is in 1..MAX_LAT.
  - c[i_lat] is invalid (no writeback-port collision).
  - o_s_busy[i_dest] is 0 (WAW).
  - If i_srcj_use, o_s_busy[i_srcj] is 0 (RAW); if i_srck_use, o_s_busy[i_srck] is 0 (RAW).
- Illegal latency: o_err is high and o_grant is low. o_stall stays low; the issue stage must trap, not retry.
- Busy bits:
  - Set at the posedge that ends a granted cycle.
  - Cleared at the posedge ending the cycle in which o_wb_valid is high for that index.
  - If set and clear hit the same bit in the same cycle, set wins. This cannot occur without the bypass feature because busy blocks the grant.
- o_pending:
  - +1 on grant, -1 when o_wb_valid is high, unchanged when both occur.
  - Never exceeds MAX_LAT.
- A writeback and a new grant may coexist in the same cycle for different registers.
- No back-pressure: once granted, a writeback always occurs exactly L cycles later.
- Reset:
  - All chain slots invalid, o_wb_valid=0, o_wb_dest=0, o_wb_unit=0, o_s_busy=0, o_pending=0.
  - In-flight reservations are discarded. Results arriving from units afterwards are ignored because no strobe is issued.
  - While rst is high, o_grant is forced to 0 and o_err is forced to 0.

Optional Feature:
- Macro: S_SCHED_WB_BYPASS_EN.
- Defined: a busy bit whose writeback is on o_wb_valid in the current cycle counts as free for the RAW and WAW checks.
  - Allows back-to-back dependent issue.
  - Requires the S-file write-through path to the operand read.
  - The WAW set-wins rule applies.
- Undefined: busy bits block until cleared, costing one extra cycle per dependency.

Test Plan:
- Reset, then issue unit=0 lat=2 dest=3 at cycle 10:
  - o_grant=1 in cycle 10.
  - o_s_busy=0x08 from cycle 11.
  - o_wb_valid=1, dest=3, unit=0 in cycle 12 only.
  - busy=0 from cycle 13; o_pending goes 0→1→0.
- Slot collision: cycle 10 lat=6 dest=1 granted; cycle 11 lat=5 dest=2:
  - Cycle 11 has o_stall=1.
  - Held request is granted in cycle 12; writebacks occur in cycles 16 and 17.
- RAW: dest=4 lat=3 granted in cycle 10; request with srcj_use=1 srcj=4 from cycle 11:
  - Stalls through cycle 13 and is granted in cycle 14.
  - With S_SCHED_WB_BYPASS_EN, it is granted in cycle 13.
- Illegal latency: i_lat=0 and then i_lat=15 → o_err=1, o_grant=0, o_stall=0, no state change.
- Full chain: grants with lat=14..1 on consecutive cycles, distinct dests mod 8 with WAW stalls honoured → o_pending never exceeds 14; writebacks occur in correct order with no two in one cycle.
- Reset mid-flight: assert rst in cycle 12 with three entries pending → o_wb_valid stays 0 thereafter; busy=0 and pending=0 after the reset posedge.
